cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception controller at the end of the memory stage. Consumes the per-instruction exception code produced by the M-stage exception checker together with external hardware interrupts, decides whether to take a trap, and records SR/Cause/EPC state. Drives the pipeline-wide flush/redirect request. Serves `mfc0`, `mtc0` and `eret` for the datapath.

## Interface
Parameters:
- `HANDLER_PC`, 32'h0000_4180, trap entry address driven on `handler_pc` when `req` is high.
- `PRID`, 32'h2024_1127, constant returned for reads of register 15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `en`  in  1  `mtc0` write enable for the M-stage instruction.
- `cp0_addr`  in  5  CP0 register number for read and write.
- `cp0_in`  in  32  `mtc0` write data.
- `cp0_out`  out  32  `mfc0` read data, combinational from current register state.
- `vpc`  in  32  PC of the M-stage instruction.
- `bd_in`  in  1  M-stage instruction sits in a branch delay slot.
- `exc_code_in`  in  6  bit 5 is the valid flag; [4:0] is the ExcCode (4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov).
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `exl_clr`  in  1  `eret` in M stage.
- `req`  out  1  take trap now: flush F..M and redirect to `handler_pc`.
- `handler_pc`  out  32  constant `HANDLER_PC`.
- `epc_out`  out  32  current EPC register, used by `eret` redirect.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): `PRID`.
  - Any other address reads 0.
- Interrupt pending: `int_req = |(SR.IM & hw_int) & SR.IE & ~SR.EXL`.
- Exception pending: `exc_req = exc_code_in[5] & ~SR.EXL`.
- `req = int_req | exc_req`, combinational.
- Priority: interrupts beat exceptions. When both are pending, Cause.ExcCode is 0.
- On a clock edge with `req`=1:
  - SR.EXL ← 1.
  - Cause.BD ← `bd_in`.
  - Cause.ExcCode ← `int_req ? 5'd0 : exc_code_in[4:0]`.
  - EPC ← `bd_in ? vpc-4 : vpc`, then masked with 32'hFFFF_FFFC.
  - The `mtc0` write and `exl_clr` are both ignored in this cycle.
- Otherwise, on a clock edge:
  - If `exl_clr`=1, SR.EXL ← 0.
  - If `en`=1, write `cp0_in` by `cp0_addr`:
    - SR: only IM, EXL and IE are updated.
    - EPC: the full 32 bits are written.
    - Cause and PRId writes are ignored.
  - If `exl_clr` and an `en` write to SR occur in the same cycle, `exl_clr` wins for EXL; the IM and IE bits still come from the write.
- Every cycle, regardless of `req`: Cause.IP ← `hw_int`, with no masking.
- Arithmetic: `vpc-4` is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: SR = 0, Cause = 0, EPC = 0.
  - Outputs under reset: `req` = 0, `cp0_out` = the selected register's reset value, `epc_out` = 0, `handler_pc` = `HANDLER_PC`.
- `req` has zero latency: it follows the current-cycle inputs and registered SR.
- Register effects are visible on `cp0_out` and `epc_out` one cycle after the edge.
- No bypass on reads: a `mtc0` to EPC followed immediately by `eret` must be stalled by the hazard unit.
- Once EXL=1, both `int_req` and `exc_req` stay 0 until EXL is cleared by `eret` or by an `mtc0` to SR.
- Reset asserted mid-trap, including in the same cycle as `req`: state clears immediately and the trap is not recorded.
- Cause.IP lags `hw_int` by one cycle. `int_req` uses the live `hw_int`.

## Test plan
- Reset, then `mtc0` SR ← 32'h0000_0401. Assert `hw_int`=6'b000001 with `vpc`=32'h0000_3008 and `bd_in`=0.
  - Required: `req`=1 that cycle.
  - Next cycle: EPC=32'h0000_3008, Cause=32'h0000_0400, SR.EXL=1, `req`=0 despite `hw_int` still high.
- `exc_code_in`=6'b100101 (AdES, valid) with `vpc`=32'h0000_300C, `bd_in`=1, SR=0.
  - Required: `req`=1.
  - Next cycle: EPC=32'h0000_3008, Cause=32'h8000_0014.
- Interrupt and AdEL pending together (SR=32'h0000_FC01, `hw_int`=6'b100000, `exc_code_in`=6'b100100).
  - Required: ExcCode=0 and Cause.IP=6'b100000.
- `req` with `en`=1 writing EPC=32'h1234_5678.
  - Required: the write is dropped and EPC holds the trap PC.
  - Then `exl_clr`: EXL→0 and `epc_out` is unchanged.
- `mfc0` of registers 15, 13 and 7 after reset.
  - Required: `cp0_out` = 32'h2024_1127, 0 and 0 respectively.
- Assert `reset` asynchronously between edges while EXL=1 and EPC≠0.
  - Required: SR, Cause and EPC read 0 immediately, before the next edge.

Source files
------------

// File: rtl/cp0_exc_ctrl_if.sv
// Datapath-side bundle for the CP0 exception controller: M-stage exception and
// interrupt inputs, mfc0/mtc0/eret access, and the trap redirect request.
interface cp0_exc_ctrl_if;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_in;
   logic [31:0] cp0_out;
   logic [31:0] vpc;
   logic        bd_in;
   logic [5:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        exl_clr;
   logic        req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   modport master (
      output en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
      input  cp0_out, req, handler_pc, epc_out
   );

   modport slave (
      input  en, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
      output cp0_out, req, handler_pc, epc_out
   );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: decides traps at the end of M, records SR/Cause/EPC,
// and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID       = 32'h2024_1127
) (
   input logic           clk,
   input logic           reset,
   cp0_exc_ctrl_if.slave bus
);

   localparam logic [4:0] AddrSr    = 5'd12;
   localparam logic [4:0] AddrCause = 5'd13;
   localparam logic [4:0] AddrEpc   = 5'd14;
   localparam logic [4:0] AddrPrid  = 5'd15;

   logic [5:0]  srIm;
   logic        srExl;
   logic        srIe;
   logic        causeBd;
   logic [5:0]  causeIp;
   logic [4:0]  causeExc;
   logic [31:0] epc;

   logic        intReq;
   logic        excReq;
   logic        trap;
   logic [31:0] trapPc;

   assign intReq = (|(srIm & bus.hw_int)) & srIe & ~srExl;
   assign excReq = bus.exc_code_in[5] & ~srExl;
   assign trap   = intReq | excReq;
   assign trapPc = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;

   // Reset masks the request so a trap coinciding with reset never escapes.
   assign bus.req        = trap & ~reset;
   assign bus.handler_pc = HANDLER_PC;
   assign bus.epc_out    = epc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         srIm     <= '0;
         srExl    <= 1'b0;
         srIe     <= 1'b0;
         causeBd  <= 1'b0;
         causeIp  <= '0;
         causeExc <= '0;
         epc      <= '0;
      end else begin
         causeIp <= bus.hw_int;
         if (trap) begin
            srExl    <= 1'b1;
            causeBd  <= bus.bd_in;
            causeExc <= intReq ? 5'd0 : bus.exc_code_in[4:0];
            epc      <= trapPc & 32'hFFFF_FFFC;
         end else begin
            if (bus.en && bus.cp0_addr == AddrSr) begin
               srIm  <= bus.cp0_in[15:10];
               // eret in the same cycle overrides the written EXL bit
               srExl <= bus.cp0_in[1] & ~bus.exl_clr;
               srIe  <= bus.cp0_in[0];
            end else if (bus.exl_clr) begin
               srExl <= 1'b0;
            end
            if (bus.en && bus.cp0_addr == AddrEpc) begin
               epc <= bus.cp0_in;
            end
         end
      end
   end

   always_comb begin
      bus.cp0_out = '0;
      case (bus.cp0_addr)
         AddrSr:    bus.cp0_out = {16'b0, srIm, 8'b0, srExl, srIe};
         AddrCause: bus.cp0_out = {causeBd, 15'b0, causeIp, 3'b0, causeExc, 2'b0};
         AddrEpc:   bus.cp0_out = epc;
         AddrPrid:  bus.cp0_out = PRID;
         default:   bus.cp0_out = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: a vector table chained from reset plus
// hand-written reset sequences.
module tb_cp0_exc_ctrl;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   cp0_exc_ctrl_if bus ();

   cp0_exc_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] din;
      logic [31:0] vpc;
      logic        bd;
      logic [5:0]  exc;
      logic [5:0]  hw;
      logic        exlClr;
      logic        expReq;
      logic [31:0] expSr;
      logic [31:0] expCause;
      logic [31:0] expEpc;
   } vec_t;

   localparam int NumVec = 14;
   vec_t vecs[NumVec];

   function automatic vec_t mk(logic en, logic [4:0] addr, logic [31:0] din, logic [31:0] vpc,
                               logic bd, logic [5:0] exc, logic [5:0] hw, logic exlClr,
                               logic expReq, logic [31:0] expSr, logic [31:0] expCause,
                               logic [31:0] expEpc);
      vec_t v;
      v.en = en; v.addr = addr; v.din = din; v.vpc = vpc; v.bd = bd; v.exc = exc;
      v.hw = hw; v.exlClr = exlClr; v.expReq = expReq; v.expSr = expSr;
      v.expCause = expCause; v.expEpc = expEpc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic readReg(input logic [4:0] a, output logic [31:0] d);
      bus.cp0_addr = a;
      #1;
      d = bus.cp0_out;
   endtask

   task automatic checkRegs(input string tag, input logic [31:0] sr, input logic [31:0] cause,
                            input logic [31:0] epc);
      logic [31:0] d;
      readReg(5'd12, d); check({tag, " SR"}, d, sr);
      readReg(5'd13, d); check({tag, " Cause"}, d, cause);
      readReg(5'd14, d); check({tag, " EPC"}, d, epc);
      check({tag, " epc_out"}, bus.epc_out, epc);
   endtask

   task automatic idle();
      bus.en = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_in = '0; bus.vpc = '0;
      bus.bd_in = 1'b0; bus.exc_code_in = '0; bus.hw_int = '0; bus.exl_clr = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      total = 0;
      bad   = 0;

      //                en    addr   din           vpc           bd    exc        hw         clr   req   SR            Cause         EPC
      vecs[0]  = mk(1'b1, 5'd12, 32'h0000_0401, 32'h0,        1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 32'h0000_0401, 32'h0000_0000, 32'h0000_0000);
      vecs[1]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_3008, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b1, 32'h0000_0403, 32'h0000_0400, 32'h0000_3008);
      vecs[2]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_3010, 1'b0, 6'b000000, 6'b000001, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0000_3008);
      vecs[3]  = mk(1'b1, 5'd12, 32'h0000_0000, 32'h0,        1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3008);
      vecs[4]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_300C, 1'b1, 6'b100101, 6'b000000, 1'b0, 1'b1, 32'h0000_0002, 32'h8000_0014, 32'h0000_3008);
      vecs[5]  = mk(1'b1, 5'd12, 32'h0000_FC03, 32'h0,        1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 32'h0000_FC01, 32'h8000_0014, 32'h0000_3008);
      vecs[6]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_2000, 1'b0, 6'b100100, 6'b100000, 1'b0, 1'b1, 32'h0000_FC03, 32'h0000_8000, 32'h0000_2000);
      vecs[7]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 32'h0000_FC01, 32'h0000_0000, 32'h0000_2000);
      vecs[8]  = mk(1'b1, 5'd14, 32'h1234_5678, 32'h0000_4006, 1'b0, 6'b101100, 6'b000000, 1'b0, 1'b1, 32'h0000_FC03, 32'h0000_0030, 32'h0000_4004);
      vecs[9]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 32'h0000_FC01, 32'h0000_0030, 32'h0000_4004);
      vecs[10] = mk(1'b1, 5'd14, 32'h1234_5678, 32'h0,        1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 32'h0000_FC01, 32'h0000_0030, 32'h1234_5678);
      vecs[11] = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,        1'b0, 6'b000000, 6'b000000, 1'b0, 1'b0, 32'h0000_FC01, 32'h0000_0030, 32'h1234_5678);
      vecs[12] = mk(1'b0, 5'd0,  32'h0,         32'h0000_0002, 1'b1, 6'b101010, 6'b000000, 1'b0, 1'b1, 32'h0000_FC03, 32'h8000_0028, 32'hFFFF_FFFC);
      vecs[13] = mk(1'b0, 5'd0,  32'h0,         32'h0000_0100, 1'b0, 6'b101010, 6'b000000, 1'b0, 1'b0, 32'h0000_FC03, 32'h8000_0028, 32'hFFFF_FFFC);

      // Reset state, reads of PRId / Cause / unmapped, and req gated while in reset.
      idle();
      reset = 1'b1;
      bus.exc_code_in = 6'b100100;
      #1;
      check("req under reset", {31'b0, bus.req}, 32'h0);
      check("handler_pc", bus.handler_pc, 32'h0000_4180);
      readReg(5'd15, d); check("mfc0 15", d, 32'h2024_1127);
      readReg(5'd13, d); check("mfc0 13", d, 32'h0);
      readReg(5'd7, d);  check("mfc0 7", d, 32'h0);
      checkRegs("reset", 32'h0, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      idle();
      reset = 1'b0;

      for (int i = 0; i < NumVec; i++) begin
         @(negedge clk);
         bus.en = vecs[i].en; bus.cp0_addr = vecs[i].addr; bus.cp0_in = vecs[i].din;
         bus.vpc = vecs[i].vpc; bus.bd_in = vecs[i].bd; bus.exc_code_in = vecs[i].exc;
         bus.hw_int = vecs[i].hw; bus.exl_clr = vecs[i].exlClr;
         #1;
         check($sformatf("v%0d req", i), {31'b0, bus.req}, {31'b0, vecs[i].expReq});
         @(posedge clk);
         #1;
         checkRegs($sformatf("v%0d", i), vecs[i].expSr, vecs[i].expCause, vecs[i].expEpc);
      end

      // Asynchronous reset between edges while EXL=1 and EPC != 0.
      @(negedge clk);
      bus.en = 1'b0; bus.exl_clr = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      checkRegs("async reset", 32'h0, 32'h0, 32'h0);
      check("async reset req", {31'b0, bus.req}, 32'h0);

      // Hold reset across an edge with a valid exception pending: nothing recorded.
      bus.vpc = 32'h0000_5000;
      @(posedge clk);
      #1;
      checkRegs("reset hold", 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkRegs("after reset", 32'h0, 32'h0, 32'h0);
      check("req after reset", {31'b0, bus.req}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
